stopwatch_timer: RTL and testbench

Parametrised successor of the stopwatch counter core. Adds a prescaled count tick, synchronous clear and preload, an up or down (countdown) mode with expiry detection, and a wrap or saturate policy. Sits between the debounced button/switch logic and the display driver. Output value is a plain binary count; BCD conversion is done downstream.

---
 rtl/stopwatch_pkg.sv | 12 +
 rtl/stopwatch_prescaler.sv | 34 +++
 rtl/stopwatch_timer.sv | 146 ++++++++++++++
 tb/tb_stopwatch_timer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared types and helpers for the stopwatch timer slice.
//   stopwatch_state_t : FSM state encoding (IDLE / RUN / DONE)
//   presc_width()     : prescaler counter width, $clog2(PRESCALE) but at least 1
package stopwatch_pkg;

  typedef enum logic [1:0] {STATE_IDLE, STATE_RUN, STATE_DONE} stopwatch_state_t;

  function automatic int presc_width(input int prescale);
    return (prescale < 2) ? 1 : $clog2(prescale);
  endfunction

endpackage

// File: rtl/stopwatch_prescaler.sv
// stopwatch_prescaler: divides clk into one count tick every PRESCALE cycles.
//   clk, rst : clock, asynchronous active-high reset
//   enable   : count while high; count is forced to 0 while low
//   tick     : combinational, high in the cycle the count sits at PRESCALE-1
//              (and enable is high)
module stopwatch_prescaler
  import stopwatch_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int PW = presc_width(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (enable && cnt_q != LAST) cnt_d = cnt_q + 1'b1;
  end

  assign tick = enable && (cnt_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/stopwatch_timer.sv
// stopwatch_timer: prescaled up/down stopwatch counter with expiry detection.
//   clk, rst       : clock, asynchronous active-high reset
//   start/stop     : level requests; 10 = run, 01 = pause, 00/11 = hold
//   clear          : synchronous clear, highest priority
//   load/load_value: synchronous preload, ignored while running
//   mode_down      : 0 = count up, 1 = count down (sampled each tick)
//   lap            : lap capture request (used only with the lap feature)
//   counter_value  : registered count
//   running        : state is RUN
//   expired        : sticky, countdown reached 0 (cleared by clear/load)
//   overflow       : one-cycle pulse on up-mode wrap (SATURATE=0)
//   lap_value      : captured count, tied to 0 without the lap feature
// Optional feature macro: STOPWATCH_LAP_CAPTURE_EN
module stopwatch_timer
  import stopwatch_pkg::*;
#(
  parameter int N        = 16,
  parameter int PRESCALE = 1,
  parameter int SATURATE = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  input  logic         clear,
  input  logic         load,
  input  logic [N-1:0] load_value,
  input  logic         mode_down,
  input  logic         lap,
  output logic [N-1:0] counter_value,
  output logic         running,
  output logic         expired,
  output logic         overflow,
  output logic [N-1:0] lap_value
);

  localparam logic [N-1:0] CNT_MAX = '1;
  localparam logic [N-1:0] CNT_ONE = N'(1);

  stopwatch_state_t state_q, state_d, state_base;
  logic [N-1:0] cnt_q, cnt_d;
  logic         exp_q, exp_d;
  logic         ovf_q, ovf_d;
  logic         tick;
  logic         run_en;

  // Command-driven next state. The prescaler keys off this (not state_d) so
  // the countdown-to-DONE transition below does not loop back into tick.
  always_comb begin
    state_base = state_q;
    if (clear)
      state_base = STATE_IDLE;
    else if (load && state_q != STATE_RUN)
      state_base = STATE_IDLE;
    else if (start && !stop) begin
      // A finished countdown cannot be restarted in down mode.
      if (!(state_q == STATE_DONE && mode_down)) state_base = STATE_RUN;
    end else if (stop && !start && state_q == STATE_RUN)
      state_base = STATE_IDLE;
  end

  assign run_en = (state_base == STATE_RUN);

  stopwatch_prescaler #(.PRESCALE(PRESCALE)) u_presc (
    .clk    (clk),
    .rst    (rst),
    .enable (run_en),
    .tick   (tick)
  );

  always_comb begin
    state_d = state_base;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    ovf_d   = 1'b0;
    if (clear) begin
      cnt_d = '0;
      exp_d = 1'b0;
    end else if (load && state_q != STATE_RUN) begin
      cnt_d = load_value;
      exp_d = 1'b0;
    end else if (tick) begin
      if (!mode_down) begin
        if (cnt_q == CNT_MAX) begin
          if (SATURATE == 0) begin
            cnt_d = '0;
            ovf_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        // Reaching 0, or ticking while already at 0, finishes the countdown.
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0 || cnt_q == CNT_ONE) begin
          state_d = STATE_DONE;
          exp_d   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= STATE_IDLE;
      cnt_q   <= '0;
      exp_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      ovf_q   <= ovf_d;
    end
  end

  assign counter_value = cnt_q;
  assign running       = (state_q == STATE_RUN);
  assign expired       = exp_q;
  assign overflow      = ovf_q;

`ifdef STOPWATCH_LAP_CAPTURE_EN
  logic [N-1:0] lap_q, lap_d;

  // Captures the value being registered on this edge, not the current one.
  always_comb begin
    lap_d = lap_q;
    if (clear)
      lap_d = '0;
    else if (lap && state_q == STATE_RUN)
      lap_d = cnt_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lap_q <= '0;
    else     lap_q <= lap_d;
  end

  assign lap_value = lap_q;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign lap_value  = '0;
`endif

endmodule

// File: tb/tb_stopwatch_timer.sv
// tb_stopwatch_timer: two stopwatch instances driven by shared stimulus.
//   dut0 : N=8, PRESCALE=4, SATURATE=0
//   dut1 : N=8, PRESCALE=1, SATURATE=1
// Each is compared every cycle against a behavioural model.
module tb_stopwatch_timer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, stop, clear, load, mode_down, lap;
  logic [7:0] load_value;
  logic [7:0] cv0, lv0, cv1, lv1;
  logic       run0, exp0, ovf0, run1, exp1, ovf1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stopwatch_timer #(.N(8), .PRESCALE(4), .SATURATE(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
    .load(load), .load_value(load_value), .mode_down(mode_down), .lap(lap),
    .counter_value(cv0), .running(run0), .expired(exp0), .overflow(ovf0),
    .lap_value(lv0)
  );

  stopwatch_timer #(.N(8), .PRESCALE(1), .SATURATE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
    .load(load), .load_value(load_value), .mode_down(mode_down), .lap(lap),
    .counter_value(cv1), .running(run1), .expired(exp1), .overflow(ovf1),
    .lap_value(lv1)
  );

  // Model: run/done flags, integer count, cycles elapsed in current tick period.
  typedef struct {
    bit run;
    bit done;
    int val;
    int phase;
    bit exp;
    bit ovf;
    int lapv;
  } mdl_t;

  mdl_t m0, m1;

  function automatic mdl_t mreset();
    mdl_t m;
    m.run = 0; m.done = 0; m.val = 0; m.phase = 0;
    m.exp = 0; m.ovf = 0; m.lapv = 0;
    return m;
  endfunction

  function automatic mdl_t step(input mdl_t m, input int p, input bit sat);
    mdl_t r;
    bit go, fin;
    r = m;
    r.ovf = 0;
    if (clear) return mreset();
    if (load && !m.run) begin
      r.val = int'(load_value); r.exp = 0; r.done = 0; r.phase = 0;
      return r;
    end
    go  = m.run;
    fin = 0;
    if (start && !stop && !(m.done && mode_down)) go = 1;
    if (stop && !start) go = 0;
    if (!go) r.phase = 0;
    else if (m.phase == p - 1) begin
      r.phase = 0;
      if (!mode_down) begin
        if (m.val == 255) begin
          if (!sat) begin r.val = 0; r.ovf = 1; end
        end else r.val = m.val + 1;
      end else begin
        if (m.val > 0) r.val = m.val - 1;
        if (r.val == 0) fin = 1;
      end
    end else r.phase = m.phase + 1;
    r.run  = go && !fin;
    r.done = fin ? 1'b1 : (go ? 1'b0 : m.done);
    if (fin) r.exp = 1;
    if (lap && m.run) r.lapv = r.val;
    return r;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s @%0t got=%0h want=%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic cmp_all();
    int l0, l1;
`ifdef STOPWATCH_LAP_CAPTURE_EN
    l0 = m0.lapv; l1 = m1.lapv;
`else
    l0 = 0; l1 = 0;
`endif
    chk("cv0", int'(cv0), m0.val);  chk("run0", int'(run0), int'(m0.run));
    chk("exp0", int'(exp0), int'(m0.exp)); chk("ovf0", int'(ovf0), int'(m0.ovf));
    chk("lap0", int'(lv0), l0);
    chk("cv1", int'(cv1), m1.val);  chk("run1", int'(run1), int'(m1.run));
    chk("exp1", int'(exp1), int'(m1.exp)); chk("ovf1", int'(ovf1), int'(m1.ovf));
    chk("lap1", int'(lv1), l1);
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!rst) begin
      m0 = step(m0, 4, 1'b0);
      m1 = step(m1, 1, 1'b1);
    end
    #1;
    cmp_all();
  endtask

  task automatic set_in(input bit s, input bit t, input bit c, input bit l,
                        input logic [7:0] lv, input bit md, input bit lp);
    start = s; stop = t; clear = c; load = l; load_value = lv;
    mode_down = md; lap = lp;
  endtask

  // Reset between clock edges; outputs must clear before the next edge.
  task automatic arst();
    @(negedge clk);
    rst = 1'b1;
    set_in(0, 0, 0, 0, 8'h00, 0, 0);
    m0 = mreset(); m1 = mreset();
    #1;
    cmp_all();
    #1 rst = 1'b0;
  endtask

  initial begin
    set_in(0, 0, 0, 0, 8'h00, 0, 0);
    rst = 1'b1;
    m0 = mreset(); m1 = mreset();
    #3 cmp_all();
    #9 rst = 1'b0;

    // Up count, pause, both-pressed hold, resume.
    set_in(1, 0, 0, 0, 8'h00, 0, 0); repeat (3) cyc();
    start = 0;                       repeat (14) cyc();
    stop = 1;                        repeat (4) cyc();
    start = 1;                       repeat (4) cyc();
    stop = 0;                        repeat (6) cyc();

    // Async reset mid-run at 0x23, then no counting until start.
    set_in(0, 1, 0, 0, 8'h00, 0, 0); cyc();
    set_in(0, 0, 0, 1, 8'h21, 0, 0); cyc();
    set_in(1, 0, 0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 40 && cv0 != 8'h23; i++) cyc();
    chk("val_23", int'(cv0), 8'h23);
    arst();
    repeat (6) cyc();

    // Up-mode boundary from 0xFF: wrap+overflow on dut0, saturate on dut1.
    set_in(0, 0, 0, 1, 8'hFF, 0, 0); cyc();
    start = 1; load = 0;             repeat (10) cyc();

    // Countdown from 3; start held in DONE is ignored; then clear.
    set_in(0, 1, 0, 0, 8'h00, 1, 0); cyc();
    set_in(0, 0, 0, 1, 8'h03, 1, 0); cyc();
    set_in(1, 0, 0, 0, 8'h00, 1, 0); repeat (20) cyc();
    chk("cd_exp", int'(exp0), 1);
    clear = 1; start = 0;            repeat (2) cyc();
    clear = 0;                       cyc();

    // Load ignored while running; clear beats start.
    set_in(0, 0, 0, 1, 8'h10, 0, 0); cyc();
    set_in(1, 0, 0, 0, 8'h00, 0, 0); repeat (3) cyc();
    set_in(1, 0, 0, 1, 8'h55, 0, 0); repeat (3) cyc();
    load = 0;                        repeat (3) cyc();
    clear = 1;                       cyc();
    set_in(0, 0, 0, 0, 8'h00, 0, 0); repeat (2) cyc();

    // Lap capture as dut1 (PRESCALE=1) registers 0x07.
    set_in(1, 0, 0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 12; i++) begin
      lap = (m1.val == 6);
      cyc();
    end
    lap = 0; repeat (4) cyc();

    // Randomized traffic.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 599) == 0) arst();
      clear = ($urandom_range(0, 63) == 0);
      load  = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0:       load_value = 8'($urandom);
        1:       load_value = 8'($urandom_range(250, 255));
        default: load_value = 8'($urandom_range(0, 4));
      endcase
      start = ($urandom_range(0, 9) < 6);
      stop  = ($urandom_range(0, 9) < 2);
      if ($urandom_range(0, 31) == 0) mode_down = ~mode_down;
      lap = ($urandom_range(0, 7) == 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
